// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss
// Loadable minutes:seconds down-counter clocked by the 1 Hz timebase, with a
// start/pause/done state machine, a registered minute-borrow pulse and BCD
// digit outputs for the 7-segment display path.
//
// Ports:
//   clk_1     1 Hz counting clock, all state changes on its rising edge
//   rst       asynchronous active-high reset
//   load      pulse, captures min_in/sec_in (clamped) unless running
//   min_in    minute preset, binary
//   sec_in    second preset, binary
//   start     pulse, start/pause toggle
//   clear     pulse, forces 00:00 and IDLE
//   min_cnt   current minutes, binary
//   sec_cnt   current seconds, binary
//   min_tens, min_ones, sec_tens, sec_ones   BCD digits of the counts
//   state     IDLE=00, RUN=01, PAUSE=10, DONE=11
//   bw_min    one-cycle pulse after each seconds reload on a minute borrow
//   done      level, high while in DONE
module countdown_timer_mmss #(
  parameter int unsigned MAX_MIN = 59,
  parameter int unsigned MAX_SEC = 59
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       start,
  input  logic       clear,
  output logic [6:0] min_cnt,
  output logic [5:0] sec_cnt,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       bw_min,
  output logic       done
);

  localparam int unsigned MIN_W = 7;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned BCD_W = 4;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam logic [MIN_W-1:0] MIN_LIM = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] SEC_LIM = SEC_W'(MAX_SEC);

  logic [1:0]       state_nxt;
  logic [MIN_W-1:0] min_nxt;
  logic [SEC_W-1:0] sec_nxt;
  logic             bw_nxt;
  logic [MIN_W-1:0] min_clamp;
  logic [SEC_W-1:0] sec_clamp;
  logic             count_zero;

  // Out-of-range presets saturate at the configured limits
  assign min_clamp  = (min_in > MIN_LIM) ? MIN_LIM : min_in;
  assign sec_clamp  = (sec_in > SEC_LIM) ? SEC_LIM : sec_in;
  assign count_zero = (min_cnt == '0) && (sec_cnt == '0);

  // State and count registers
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      min_cnt <= '0;
      sec_cnt <= '0;
      bw_min  <= 1'b0;
    end else begin
      state   <= state_nxt;
      min_cnt <= min_nxt;
      sec_cnt <= sec_nxt;
      bw_min  <= bw_nxt;
    end
  end

  // Next state / next count; priority clear > load > start > counting.
  // A load while running is ignored and also swallows a same-cycle start.
  always_comb begin
    state_nxt = state;
    min_nxt   = min_cnt;
    sec_nxt   = sec_cnt;
    bw_nxt    = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      min_nxt   = '0;
      sec_nxt   = '0;
    end else if (load && (state != RUN)) begin
      state_nxt = IDLE;
      min_nxt   = min_clamp;
      sec_nxt   = sec_clamp;
    end else if (start && !load) begin
      case (state)
        IDLE:    if (!count_zero) state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end else if (state == RUN) begin
      if (sec_cnt != '0) begin
        sec_nxt = sec_cnt - SEC_W'(1);
        if ((min_cnt == '0) && (sec_cnt == SEC_W'(1))) state_nxt = DONE;
      end else if (min_cnt != '0) begin
        sec_nxt = SEC_LIM;
        min_nxt = min_cnt - MIN_W'(1);
        bw_nxt  = 1'b1;
      end else begin
        state_nxt = DONE;
      end
    end
  end

  assign done = (state == DONE);

  // Display digits derived directly from the binary counts
  assign min_tens = BCD_W'(min_cnt / MIN_W'(10));
  assign min_ones = BCD_W'(min_cnt % MIN_W'(10));
  assign sec_tens = BCD_W'(sec_cnt / SEC_W'(10));
  assign sec_ones = BCD_W'(sec_cnt % SEC_W'(10));

endmodule
